// File: rtl/pcie_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the PCIe core's AXI4-Stream TX port.
// Optional macro PCIE_TX_ARB_CFG_PRIORITY_EN: registered config-TLP grant that pre-empts new user grants.
module pcie_tx_arbiter #(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH/8,
    parameter int NUM_REQ      = 4,
    parameter int MIN_BUF_AV   = 2
) (
    input  logic                            user_clk,
    input  logic                            user_reset_n,
    input  logic                            user_lnk_up,
    input  logic [5:0]                      tx_buf_av,
    input  logic                            tx_cfg_req,
    output logic                            tx_cfg_gnt,
    input  logic [NUM_REQ*C_DATA_WIDTH-1:0] req_tdata,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0]   req_tkeep,
    input  logic [NUM_REQ*4-1:0]            req_tuser,
    input  logic [NUM_REQ-1:0]              req_tlast,
    input  logic [NUM_REQ-1:0]              req_tvalid,
    output logic [NUM_REQ-1:0]              req_tready,
    output logic [NUM_REQ-1:0]              req_gnt,
    output logic [C_DATA_WIDTH-1:0]         s_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]           s_axis_tx_tkeep,
    output logic [3:0]                      s_axis_tx_tuser,
    output logic                            s_axis_tx_tlast,
    output logic                            s_axis_tx_tvalid,
    input  logic                            s_axis_tx_tready
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, XFER} state_t;

    state_t           state;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             sel_vld;
    logic             cfg_hold;
    logic             eligible;
    logic             pkt_end;
    int               cand;

    logic [C_DATA_WIDTH-1:0] lane_data [NUM_REQ];
    logic [KEEP_WIDTH-1:0]   lane_keep [NUM_REQ];
    logic [3:0]              lane_user [NUM_REQ];

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_lane
            assign lane_data[g]  = req_tdata[g*C_DATA_WIDTH +: C_DATA_WIDTH];
            assign lane_keep[g]  = req_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH];
            assign lane_user[g]  = req_tuser[g*4 +: 4];
            assign req_tready[g] = (state == XFER) && (gnt_idx == IDX_W'(g)) && s_axis_tx_tready;
        end
    endgenerate

    // No buffering: the granted requester is wired straight through while in XFER.
    assign s_axis_tx_tdata  = lane_data[gnt_idx];
    assign s_axis_tx_tkeep  = lane_keep[gnt_idx];
    assign s_axis_tx_tuser  = lane_user[gnt_idx];
    assign s_axis_tx_tlast  = req_tlast[gnt_idx];
    assign s_axis_tx_tvalid = (state == XFER) && req_tvalid[gnt_idx];
    assign pkt_end          = s_axis_tx_tvalid && s_axis_tx_tready && s_axis_tx_tlast;

`ifdef PCIE_TX_ARB_CFG_PRIORITY_EN
    assign cfg_hold = tx_cfg_gnt | tx_cfg_req;
`else
    logic unused_cfg_req;
    assign unused_cfg_req = tx_cfg_req;
    assign cfg_hold       = 1'b0;
    assign tx_cfg_gnt     = 1'b1;
`endif

    assign eligible = user_lnk_up && (tx_buf_av >= 6'(MIN_BUF_AV)) && !cfg_hold;

    // Scan from farthest to nearest so the nearest valid requester after last_idx wins.
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand     = (int'(last_idx) + k) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (req_tvalid[cand_idx]) begin
                sel_vld = 1'b1;
                sel_idx = cand_idx;
            end
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            last_idx <= IDX_W'(NUM_REQ-1);
            req_gnt  <= '0;
`ifdef PCIE_TX_ARB_CFG_PRIORITY_EN
            tx_cfg_gnt <= 1'b0;
`endif
        end else if (state == IDLE) begin
`ifdef PCIE_TX_ARB_CFG_PRIORITY_EN
            tx_cfg_gnt <= tx_cfg_req;
`endif
            if (eligible && sel_vld) begin
                gnt_idx <= sel_idx;
                req_gnt <= NUM_REQ'(1) << sel_idx;
                state   <= XFER;
            end
        end else if (pkt_end) begin
            last_idx <= gnt_idx;
            req_gnt  <= '0;
            state    <= IDLE;
        end
    end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: directed scenarios plus random traffic against a packet-level model.
// Honours PCIE_TX_ARB_CFG_PRIORITY_EN when defined for the whole compile.
module tb_pcie_tx_arbiter;
    localparam int N    = 4;
    localparam int DW   = 64;
    localparam int KW   = 8;
    localparam int MINB = 2;
`ifdef PCIE_TX_ARB_CFG_PRIORITY_EN
    localparam bit CFG_EN = 1'b1;
`else
    localparam bit CFG_EN = 1'b0;
`endif

    logic            user_clk = 1'b0;
    logic            user_reset_n = 1'b0;
    logic            user_lnk_up = 1'b0;
    logic [5:0]      tx_buf_av = '0;
    logic            tx_cfg_req = 1'b0;
    logic            tx_cfg_gnt;
    logic [N*DW-1:0] req_tdata;
    logic [N*KW-1:0] req_tkeep;
    logic [N*4-1:0]  req_tuser;
    logic [N-1:0]    req_tlast, req_tvalid, req_tready, req_gnt;
    logic [DW-1:0]   s_axis_tx_tdata;
    logic [KW-1:0]   s_axis_tx_tkeep;
    logic [3:0]      s_axis_tx_tuser;
    logic            s_axis_tx_tlast, s_axis_tx_tvalid;
    logic            s_axis_tx_tready = 1'b0;

    pcie_tx_arbiter dut (
        .user_clk(user_clk), .user_reset_n(user_reset_n), .user_lnk_up(user_lnk_up),
        .tx_buf_av(tx_buf_av), .tx_cfg_req(tx_cfg_req), .tx_cfg_gnt(tx_cfg_gnt),
        .req_tdata(req_tdata), .req_tkeep(req_tkeep), .req_tuser(req_tuser),
        .req_tlast(req_tlast), .req_tvalid(req_tvalid), .req_tready(req_tready),
        .req_gnt(req_gnt), .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep),
        .s_axis_tx_tuser(s_axis_tx_tuser), .s_axis_tx_tlast(s_axis_tx_tlast),
        .s_axis_tx_tvalid(s_axis_tx_tvalid), .s_axis_tx_tready(s_axis_tx_tready)
    );

    always #5 user_clk = ~user_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Source side: each requester has at most one pending packet (length 0 = none).
    int src_len[N], src_beat[N], src_pkt[N], src_more[N], src_nlen[N];
    // Model: current packet owner (-1 = none), last served requester, config grant.
    int owner, last_srv;
    bit cfg_m, auto_gen;
    int dut_beats;
    int gnt_log[$];
    logic [N-1:0] prev_gnt;

    function automatic logic [63:0] bdata(int i, int p, int b);
        logic [31:0] ii, pp, bb;
        ii = i; pp = p; bb = b;
        return {ii[7:0], pp[23:0], bb};
    endfunction

    function automatic logic [7:0] bkeep(int p, bit last);
        logic [7:0] full;
        full = 8'hFF;
        return last ? (full >> (p % 8)) : full;
    endfunction

    function automatic logic [3:0] buser(int i, int b);
        logic [31:0] x;
        x = i ^ b;
        return x[3:0];
    endfunction

    function automatic bit busy();
        bit b;
        b = (owner >= 0);
        for (int i = 0; i < N; i++) if (src_len[i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drive_inputs();
        bit last;
        for (int i = 0; i < N; i++) begin
            last = (src_beat[i] == src_len[i] - 1);
            req_tvalid[i]         = (src_len[i] > 0);
            req_tlast[i]          = (src_len[i] > 0) && last;
            req_tdata[i*DW +: DW] = bdata(i, src_pkt[i], src_beat[i]);
            req_tkeep[i*KW +: KW] = bkeep(src_pkt[i], last);
            req_tuser[i*4 +: 4]   = buser(i, src_beat[i]);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0; src_beat[i] = 0; src_more[i] = 0; src_nlen[i] = 0;
        end
        owner = -1; last_srv = N - 1; cfg_m = 1'b0; prev_gnt = '0;
        drive_inputs();
    endtask

    // One clock cycle: drive at negedge, check #1 later, advance model, wait for next negedge.
    task automatic step();
        logic [N-1:0] eg, er;
        bit ev, hold, last;
        int j;
        for (int i = 0; i < N; i++) begin
            if (src_len[i] == 0) begin
                if (src_more[i] > 0) begin
                    src_more[i]--;
                    src_len[i] = src_nlen[i];
                end else if (auto_gen && $urandom_range(3, 0) == 0) begin
                    src_len[i] = $urandom_range(5, 1);
                end
            end
        end
        if (auto_gen) begin
            s_axis_tx_tready = ($urandom_range(3, 0) != 0);
            tx_buf_av        = 6'($urandom_range(40, 0));
            user_lnk_up      = ($urandom_range(15, 0) != 0);
            tx_cfg_req       = ($urandom_range(7, 0) == 0);
        end
        drive_inputs();
        #1;
        eg = '0; er = '0; ev = 1'b0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            ev = (src_len[owner] > 0);
            if (s_axis_tx_tready) er[owner] = 1'b1;
        end
        chk("gnt", req_gnt, eg);
        chk("tready", req_tready, er);
        chk("tvalid", s_axis_tx_tvalid, ev);
        chk("cfg_gnt", tx_cfg_gnt, CFG_EN ? cfg_m : 1'b1);
        if (ev) begin
            last = (src_beat[owner] == src_len[owner] - 1);
            chk("tdata", s_axis_tx_tdata, bdata(owner, src_pkt[owner], src_beat[owner]));
            chk("keep_user_last", {s_axis_tx_tkeep, s_axis_tx_tuser, s_axis_tx_tlast},
                {bkeep(src_pkt[owner], last), buser(owner, src_beat[owner]), last});
        end
        if (req_gnt != '0 && prev_gnt == '0)
            for (int i = 0; i < N; i++) if (req_gnt[i]) gnt_log.push_back(i);
        prev_gnt = req_gnt;
        if (s_axis_tx_tvalid && s_axis_tx_tready) dut_beats++;
        if (owner >= 0) begin
            if (ev && s_axis_tx_tready) begin
                if (src_beat[owner] == src_len[owner] - 1) begin
                    src_len[owner] = 0; src_beat[owner] = 0; src_pkt[owner]++;
                    last_srv = owner; owner = -1;
                end else begin
                    src_beat[owner]++;
                end
            end
        end else begin
            hold = CFG_EN && (cfg_m || tx_cfg_req);
            if (user_lnk_up && tx_buf_av >= MINB && !hold)
                for (int k = 1; k <= N && owner < 0; k++) begin
                    j = (last_srv + k) % N;
                    if (src_len[j] > 0) owner = j;
                end
            if (CFG_EN) cfg_m = tx_cfg_req;
        end
        @(posedge user_clk);
        @(negedge user_clk);
    endtask

    initial begin
        int exp_order[4];
        bit bp_rdy[9];
        int guard;
        exp_order = '{0, 1, 3, 0};
        bp_rdy    = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        for (int i = 0; i < N; i++) src_pkt[i] = 0;
        auto_gen = 1'b0;
        clear_model();
        #3;
        chk("rst_gnt", req_gnt, '0);
        chk("rst_tvalid", s_axis_tx_tvalid, 1'b0);
        chk("rst_tready", req_tready, '0);
        chk("rst_cfg_gnt", tx_cfg_gnt, CFG_EN ? 1'b0 : 1'b1);
        @(negedge user_clk);
        @(negedge user_clk);
        user_reset_n = 1'b1; user_lnk_up = 1'b1; tx_buf_av = 6'd32; s_axis_tx_tready = 1'b1;

        // Round-robin over 0, 1, 3 with requester 0 queuing a second packet
        src_len[0] = 3; src_len[1] = 3; src_len[3] = 3; src_nlen[0] = 3; src_more[0] = 1;
        gnt_log.delete();
        repeat (20) step();
        chk("rr_count", gnt_log.size(), 4);
        for (int k = 0; k < 4; k++) if (k < gnt_log.size()) chk("rr_order", gnt_log[k], exp_order[k]);

        // Buffer gating
        tx_buf_av = 6'd1; src_len[2] = 2;
        repeat (4) step();
        chk("gate_blocked", req_gnt, '0);
        tx_buf_av = 6'd2;
        step();
        chk("gate_gnt", req_gnt, 4'b0100);
        repeat (4) step();

        // Backpressure mid-packet
        src_len[1] = 4; dut_beats = 0;
        for (int k = 0; k < 9; k++) begin
            s_axis_tx_tready = bp_rdy[k];
            step();
        end
        chk("bp_beats", dut_beats, 4);

        // Link drop on beat 2 of a 5-beat packet
        s_axis_tx_tready = 1'b1; src_len[2] = 5; dut_beats = 0;
        step();
        step();
        user_lnk_up = 1'b0; src_len[0] = 2;
        repeat (9) step();
        chk("ld_beats", dut_beats, 5);
        chk("ld_no_gnt", req_gnt, '0);
        user_lnk_up = 1'b1;
        repeat (6) step();

`ifdef PCIE_TX_ARB_CFG_PRIORITY_EN
        tx_cfg_req = 1'b1; src_len[0] = 2;
        step();
        chk("cfg_set", tx_cfg_gnt, 1'b1);
        chk("cfg_no_gnt", req_gnt, '0);
        repeat (3) step();
        chk("cfg_hold", req_gnt, '0);
        tx_cfg_req = 1'b0;
        step();
        chk("cfg_drop1", req_gnt, '0);
        step();
        chk("cfg_drop2", req_gnt, 4'b0001);
        repeat (4) step();
`endif

        // Asynchronous reset during beat 1
        src_len[0] = 4;
        step();
        drive_inputs();
        #1;
        chk("ar_pre_vld", s_axis_tx_tvalid, 1'b1);
        user_reset_n = 1'b0;
        #1;
        chk("ar_tvalid", s_axis_tx_tvalid, 1'b0);
        chk("ar_gnt", req_gnt, '0);
        chk("ar_tready", req_tready, '0);
        clear_model();
        @(negedge user_clk);
        @(negedge user_clk);
        user_reset_n = 1'b1;
        src_len[0] = 2; src_len[3] = 2;
        gnt_log.delete();
        repeat (3) step();
        chk("ar_first", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

        // Random traffic
        auto_gen = 1'b1;
        repeat (3000) step();

        auto_gen = 1'b0; user_lnk_up = 1'b1; tx_buf_av = 6'd63;
        s_axis_tx_tready = 1'b1; tx_cfg_req = 1'b0;
        guard = 0;
        while (busy() && guard < 200) begin
            step();
            guard++;
        end
        chk("drain", guard < 200, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
